// File: rtl/fetch_pkg.sv
// fetch_pkg: entry layout shared by fetch, queue and decoder
package fetch_pkg;
  localparam int DEF_IW = 16;
  localparam int DEF_PCW = 16;
  localparam int DEF_IMMW = 6;
  typedef struct packed {
    logic [DEF_IW-1:0]   instr;
    logic                pred;
    logic [DEF_PCW-1:0]  pc;
    logic [DEF_IMMW-1:0] imm;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/fetch_decode_queue_lead_ones_count.sv
// lead_ones_count: number of consecutive 1s starting at bit 0
module lead_ones_count #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  v,
  output logic [CW-1:0] n
);
  logic run;
  // walk from lane 0; the first 0 stops the run
  always_comb begin
    n = '0;
    run = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & v[i];
      n = n + CW'(run);
    end
  end
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: W-lane circular instruction queue between fetch and decode
import fetch_pkg::*;
module fetch_decode_queue #(
  parameter int W     = 2,
  parameter int DEPTH = 8,
  parameter int IW    = DEF_IW,
  parameter int PCW   = DEF_PCW,
  parameter int IMMW  = DEF_IMMW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [W-1:0]    in_valid,
  input  logic [W*IW-1:0] in_instr,
  input  logic [W-1:0]    in_pred,
  input  logic [W*PCW-1:0] in_pc,
  input  logic [W*IMMW-1:0] in_imm,
  output logic            in_ready,
  output logic [W-1:0]    out_valid,
  output logic [W*IW-1:0] out_instr,
  output logic [W-1:0]    out_pred,
  output logic [W*PCW-1:0] out_pc,
  output logic [W*IMMW-1:0] out_imm,
  input  logic [W-1:0]    out_take,
  output logic [CW-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IW + 1 + PCW + IMMW;
  localparam int PW = $clog2(W + 1);
  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr [W];
  logic [PW-1:0] p_raw, p, q;
  assign count = cnt;
  assign in_ready = cnt <= CW'(DEPTH - W);
  assign p = in_ready ? p_raw : '0;
  lead_ones_count #(.W(W)) u_push (.v(in_valid), .n(p_raw));
  lead_ones_count #(.W(W)) u_pop (.v(out_take & out_valid), .n(q));
  for (genvar g = 0; g < W; g++) begin : g_lane
    logic [EW-1:0] e;
    assign wr[g] = {in_instr[g*IW +: IW], in_pred[g], in_pc[g*PCW +: PCW], in_imm[g*IMMW +: IMMW]};
    assign e = mem[head + AW'(g)];
    assign out_valid[g] = cnt > CW'(g);
    assign {out_instr[g*IW +: IW], out_pred[g], out_pc[g*PCW +: PCW], out_imm[g*IMMW +: IMMW]} = e;
  end
  // pointer/occupancy update; the push is gated only by the registered count
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < W; i++) if (PW'(i) < p) mem[tail + AW'(i)] <= wr[i];
      tail <= tail + AW'(p);
      head <= head + AW'(q);
      cnt <= cnt + CW'(p) - CW'(q);
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: queue-model scoreboard with directed and random traffic
module tb_fetch_decode_queue;
  localparam int W = 2, DEPTH = 8;
  typedef struct {
    logic [15:0] instr;
    logic        pred;
    logic [15:0] pc;
    logic [5:0]  imm;
  } ent_t;
  logic clk = 0, rst = 1, flush = 0;
  logic [1:0] in_valid = 0, in_pred = 0, out_take = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic [11:0] in_imm = 0;
  logic in_ready;
  logic [1:0] out_valid, out_pred;
  logic [31:0] out_instr, out_pc;
  logic [11:0] out_imm;
  logic [3:0] count;
  ent_t mq[$];
  int total = 0, passed = 0, m_p, m_q, m_sz;
  bit live = 0, run;
  logic [15:0] next_pc = 0;

  fetch_decode_queue #(.W(W), .DEPTH(DEPTH), .IW(16), .PCW(16), .IMMW(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pred(in_pred), .in_pc(in_pc), .in_imm(in_imm), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pred(out_pred), .out_pc(out_pc),
    .out_imm(out_imm), .out_take(out_take), .count(count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: a plain FIFO of entries; push only when W free slots remain
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      live = 1;
    end else if (flush) mq.delete();
    else begin
      m_sz = mq.size();
      m_p = 0;
      m_q = 0;
      run = 1;
      if (DEPTH - m_sz >= W)
        for (int i = 0; i < W; i++) begin run = run & in_valid[i]; m_p += int'(run); end
      run = 1;
      for (int i = 0; i < W; i++) begin run = run & out_take[i] & (i < m_sz); m_q += int'(run); end
      for (int k = 0; k < m_q; k++) void'(mq.pop_front());
      for (int i = 0; i < m_p; i++)
        mq.push_back('{in_instr[i*16 +: 16], in_pred[i], in_pc[i*16 +: 16], in_imm[i*6 +: 6]});
      next_pc = next_pc + 16'(2 * m_p);
    end
  end

  // every cycle: DUT outputs must match the model's current contents
  always @(negedge clk) begin
    if (live) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= W));
      for (int i = 0; i < W; i++) begin
        chk("out_valid", 64'(out_valid[i]), 64'(i < mq.size()));
        if (i < mq.size()) begin
          chk("out_instr", 64'(out_instr[i*16 +: 16]), 64'(mq[i].instr));
          chk("out_pred", 64'(out_pred[i]), 64'(mq[i].pred));
          chk("out_pc", 64'(out_pc[i*16 +: 16]), 64'(mq[i].pc));
          chk("out_imm", 64'(out_imm[i*6 +: 6]), 64'(mq[i].imm));
        end
      end
    end
  end

  task automatic set(input logic [1:0] v, input logic [1:0] t);
    in_valid = v;
    out_take = t;
    for (int i = 0; i < W; i++) begin
      in_pc[i*16 +: 16] = next_pc + 16'(2 * i);
      in_instr[i*16 +: 16] = 16'($urandom);
      in_pred[i] = 1'($urandom);
      in_imm[i*6 +: 6] = 6'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_count", 64'(count), 0);
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_valid", 64'(out_valid), 0);
    set(2'b11, 2'b00);
    in_instr = {16'h5678, 16'h1234};
    tick();
    chk("push2_count", 64'(count), 2);
    chk("push2_valid", 64'(out_valid), 2'b11);
    chk("push2_lane0", 64'(out_instr[15:0]), 16'h1234);
    chk("push2_lane1", 64'(out_instr[31:16]), 16'h5678);
    chk("push2_pc1", 64'(out_pc[31:16]), 16'h0002);
    set(2'b00, 2'b01);
    tick();
    chk("replay_count", 64'(count), 1);
    chk("replay_lane0", 64'(out_instr[15:0]), 16'h5678);
    set(2'b00, 2'b01);
    tick();
    chk("drain_count", 64'(count), 0);
    for (int k = 0; k < 4; k++) begin set(2'b11, 2'b00); tick(); end
    chk("full_count", 64'(count), 8);
    chk("full_ready", 64'(in_ready), 0);
    set(2'b11, 2'b00);
    tick();
    chk("full_drop", 64'(count), 8);
    set(2'b11, 2'b11);
    tick();
    chk("full_pop_count", 64'(count), 6);
    chk("full_pop_ready", 64'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      set(2'b11, 2'b11);
      tick();
      chk("steady_count", 64'(count), 6);
      chk("steady_order", 64'(out_pc[31:16] - out_pc[15:0]), 2);
    end
    set(2'b10, 2'b10);
    tick();
    chk("nonprefix_count", 64'(count), 6);
    set(2'b00, 2'b01);
    tick();
    chk("pre_flush_count", 64'(count), 5);
    set(2'b11, 2'b11);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(out_valid), 0);
    set(2'b11, 2'b00);
    tick();
    chk("refill_count", 64'(count), 2);
    set(2'b11, 2'b11);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_count", 64'(count), 0);
    chk("rst2_ready", 64'(in_ready), 1);
    chk("rst2_valid", 64'(out_valid), 0);
    chk("rst2_instr", 64'(out_instr), 0);
    chk("rst2_pc", 64'(out_pc), 0);
    chk("rst2_pred_imm", 64'({out_pred, out_imm}), 0);
    for (int k = 0; k < 400; k++) begin
      set(2'($urandom), 2'($urandom));
      flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    set(2'b00, 2'b00);
    flush = 0;
    rst = 0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Parametrised, W-lane instruction queue between the fetch stage and the decoder.
- Successor to the fixed two-instruction fetch-to-decode handoff.
- Buffers up to DEPTH fetched instructions with their prediction bit, PC and previous immediate.
- The decoder consumes any prefix of the W head entries per cycle. Unconsumed entries stay at the head, which replaces the decoder loop-back path.

Parameters:
- W, 2, lanes pushed/presented per cycle (1..4)
- DEPTH, 8, entry count; power of two, DEPTH >= 2*W
- IW, 16, instruction width
- PCW, 16, PC width
- IMMW, 6, previous-immediate width
- CW, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all contents (branch mispredict)
- in_valid  in  W  per-lane fetch valid; lane 0 = older
- in_instr  in  W*IW  fetched instructions
- in_pred  in  W  branch-prediction bits
- in_pc  in  W*PCW  instruction PCs
- in_imm  in  W*IMMW  previous immediates
- in_ready  out  1  queue accepts a full W-lane push this cycle
- out_valid  out  W  head lane i holds a live entry
- out_instr  out  W*IW  head entries, lane 0 = oldest
- out_pred  out  W  head prediction bits
- out_pc  out  W*PCW  head PCs
- out_imm  out  W*IMMW  head immediates
- out_take  in  W  decoder consumes lane i; prefix only
- count  out  CW  current occupancy

Behaviour:
- State: head and tail pointers ($clog2(DEPTH) bits, wrap mod DEPTH), count register, DEPTH-entry storage.
- in_ready = (DEPTH - count) >= W, from registered count only. A same-cycle pop is not credited.
- Push count P = number of leading 1s of in_valid, and 0 when in_ready=0. Lanes after the first 0 are ignored.
- Lanes 0..P-1 are written at tail, tail+1, ... (mod DEPTH). Then tail += P.
- out_valid[i] = (count > i).
- Output lane i is driven combinationally from storage[head+i mod DEPTH]. Zero latency from registered state.
- Pop count Q = number of leading 1s of (out_take & out_valid). Then head += Q.
- A taken bit after a 0, or on an invalid lane, is ignored.
- Next count = count + P - Q. Simultaneous push and pop are legal, including at count == DEPTH-W.
- A pushed entry is visible on out_* in the cycle after the push. There is no bypass.
- Full: count == DEPTH, so in_ready=0. Pops still proceed.
- Empty: count == 0, so out_valid == 0. out_take is ignored.
- Wrap-around: a push or pop that straddles index DEPTH-1 → 0 stays in order.
- flush=1: next cycle head=tail=count=0. Pushes and pops in the flush cycle are discarded. Storage contents are not cleared.
- rst=1 (highest priority, including mid-push/pop/flush): head=tail=count=0 and all storage zeroed.
- Reset output values: in_ready=1, out_valid=0, out_instr/out_pred/out_pc/out_imm=0, count=0.
- Data outputs on invalid lanes are don't-care after reset, except the zeroed reset state.

Decomposition:
- Shared package fetch_pkg:
  - entry struct {instr[IW], pred, pc[PCW], imm[IMMW]}
  - ENTRY_W constant
  - default IW/PCW/IMMW
- Reuse the same package in the fetch stage and the decoder.
- One sub-module, lead_ones_count (parameter W, input [W-1:0], output count of leading 1s from bit 0). Instantiated twice, for P and Q.

Test Plan:
- Reset, then push {I=0x1234,pc=0x0000} and {I=0x5678,pc=0x0002}, in_valid=11 → next cycle count=2, out_valid=11, out_instr lane0=0x1234, lane1=0x5678.
- Two entries queued, out_take=01 → next cycle count=1, lane0 shows 0x5678. Decoder replay is covered.
- Fill to 8 with four W=2 pushes → in_ready=0 at count=8. A push attempt is dropped. A pop of 2 with push-attempt → count=6, and in_ready=1 the following cycle.
- Push and pop 2 each for 6 cycles from count=6 → count stays 6, pointers wrap past 7, and PCs appear in strict ascending order.
- in_valid=10, out_take=10 → P=0, Q=0, state unchanged.
- flush with count=5 plus simultaneous push/pop → count=0, out_valid=00. rst asserted mid-push → all outputs at reset values next cycle.
